// File: rtl/exhaustive_vector_sequencer_if.sv
// Record channel from the vector sequencer to the logging/compare stage.
// A record transfers on any rising clock edge where rec_valid && rec_ready.
interface exhaustive_vector_sequencer_if #(
  parameter int N_WIDTH   = 5,
  parameter int OUT_WIDTH = 1
);
  logic                 rec_valid;
  logic                 rec_ready;
  logic [N_WIDTH-1:0]   rec_vector;
  logic [OUT_WIDTH-1:0] rec_out;

  modport master (
    output rec_valid,
    output rec_vector,
    output rec_out,
    input  rec_ready
  );

  modport slave (
    input  rec_valid,
    input  rec_vector,
    input  rec_out,
    output rec_ready
  );
endinterface

// File: rtl/exhaustive_vector_sequencer.sv
// Exhaustive vector sequencer: drives every N_WIDTH-bit input vector to a
// benchmark circuit in ascending order, waits SETTLE_CYCLES, samples the
// circuit output and emits one (vector, output) record per vector over a
// valid/ready channel, keeping running record and hit counts.
module exhaustive_vector_sequencer #(
  parameter int N_WIDTH       = 5,
  parameter int OUT_WIDTH     = 1,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 CK,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  output logic [0:N_WIDTH-1]   N,
  input  logic [OUT_WIDTH-1:0] dut_out,
  exhaustive_vector_sequencer_if.master rec,
  output logic                 busy,
  output logic                 done,
  output logic [N_WIDTH:0]     vec_count,
  output logic [N_WIDTH:0]     hit_count
);

  localparam int CNT_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_EMIT,
    S_FINISH
  } state_e;

  state_e                state_q, state_d;
  logic [N_WIDTH-1:0]    n_q, n_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  rec_valid_q, rec_valid_d;
  logic [N_WIDTH-1:0]    rec_vector_q, rec_vector_d;
  logic [OUT_WIDTH-1:0]  rec_out_q, rec_out_d;
  logic [N_WIDTH:0]      vec_count_q, vec_count_d;
  logic [N_WIDTH:0]      hit_count_q, hit_count_d;

  // State register and datapath flops, synchronous active-high reset.
  // NOTE: every flop is updated with <= so all of them sample the pre-edge
  // values of each other; blocking writes here would create ordering races.
  always_ff @(posedge CK) begin
    if (reset) begin
      state_q      <= S_IDLE;
      n_q          <= '0;
      cnt_q        <= '0;
      rec_valid_q  <= 1'b0;
      rec_vector_q <= '0;
      rec_out_q    <= '0;
      vec_count_q  <= '0;
      hit_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      cnt_q        <= cnt_d;
      rec_valid_q  <= rec_valid_d;
      rec_vector_q <= rec_vector_d;
      rec_out_q    <= rec_out_d;
      vec_count_q  <= vec_count_d;
      hit_count_q  <= hit_count_d;
    end
  end

  // Next-state and next-datapath logic; abort outranks everything, including
  // a handshake in the same cycle, so an aborted record is never counted.
  // NOTE: every _d signal takes its hold value first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    cnt_d        = cnt_q;
    rec_valid_d  = rec_valid_q;
    rec_vector_d = rec_vector_q;
    rec_out_d    = rec_out_q;
    vec_count_d  = vec_count_q;
    hit_count_d  = hit_count_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          n_d         = '0;
          cnt_d       = SETTLE_INIT;
          vec_count_d = '0;
          hit_count_d = '0;
          state_d     = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (abort) begin
          rec_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            rec_out_d    = dut_out;
            rec_vector_d = n_q;
            rec_valid_d  = 1'b1;
            state_d      = S_EMIT;
          end
        end
      end

      S_EMIT: begin
        if (abort) begin
          rec_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else if (rec.rec_ready) begin
          rec_valid_d = 1'b0;
          vec_count_d = vec_count_q + (N_WIDTH + 1)'(1);
          if (|rec_out_q) begin
            hit_count_d = hit_count_q + (N_WIDTH + 1)'(1);
          end
          // The all-ones vector ends the sweep, so N never wraps.
          if (&n_q) begin
            state_d = S_FINISH;
          end else begin
            n_d     = n_q + N_WIDTH'(1);
            cnt_d   = SETTLE_INIT;
            state_d = S_SETTLE;
          end
        end
      end

      S_FINISH: begin
        rec_valid_d = 1'b0;
        state_d     = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_FINISH);
  end

  // N is declared MSB-first, so n_q[N_WIDTH-1] lands on N[0].
  assign N              = n_q;
  assign rec.rec_valid  = rec_valid_q;
  assign rec.rec_vector = rec_vector_q;
  assign rec.rec_out    = rec_out_q;
  assign vec_count      = vec_count_q;
  assign hit_count      = hit_count_q;

endmodule

// File: tb/tb_exhaustive_vector_sequencer.sv
// Directed bench for exhaustive_vector_sequencer: one instance with default
// timing (SETTLE_CYCLES=1) and one with SETTLE_CYCLES=3 fed by a delayed
// benchmark model. Expected vectors, outputs and cycle timings are computed
// here from the sweep definition.
module tb_exhaustive_vector_sequencer;

  logic       ck = 1'b0;
  logic       reset_s;
  logic       abort_s;
  logic       start_a;
  logic       start_b;
  logic       ready_a;
  int         mode_a;

  logic [0:4] n_a;
  logic [0:0] dut_out_a;
  logic       busy_a, done_a;
  logic [5:0] vec_a, hit_a;

  logic [0:4] n_b;
  logic [0:0] dut_out_b;
  logic       busy_b, done_b;
  logic [5:0] vec_b, hit_b;
  logic       dly1_b, dly2_b;

  int checks = 0;
  int errors = 0;

  always #5 ck = ~ck;

  exhaustive_vector_sequencer_if #(.N_WIDTH(5), .OUT_WIDTH(1)) if_a ();
  exhaustive_vector_sequencer_if #(.N_WIDTH(5), .OUT_WIDTH(1)) if_b ();

  assign if_a.rec_ready = ready_a;
  assign if_b.rec_ready = 1'b1;

  // Benchmark model A: constant 0 or the AND of all input bits.
  assign dut_out_a = (mode_a == 1) ? (&n_a) : 1'b0;

  // Benchmark model B: N[4] (the LSB) seen through a two-cycle delay.
  always @(posedge ck) begin
    dly1_b <= n_b[4];
    dly2_b <= dly1_b;
  end
  assign dut_out_b = dly2_b;

  exhaustive_vector_sequencer #(.N_WIDTH(5), .OUT_WIDTH(1), .SETTLE_CYCLES(1)) dut_a (
    .CK        (ck),
    .reset     (reset_s),
    .start     (start_a),
    .abort     (abort_s),
    .N         (n_a),
    .dut_out   (dut_out_a),
    .rec       (if_a.master),
    .busy      (busy_a),
    .done      (done_a),
    .vec_count (vec_a),
    .hit_count (hit_a)
  );

  exhaustive_vector_sequencer #(.N_WIDTH(5), .OUT_WIDTH(1), .SETTLE_CYCLES(3)) dut_b (
    .CK        (ck),
    .reset     (reset_s),
    .start     (start_b),
    .abort     (abort_s),
    .N         (n_b),
    .dut_out   (dut_out_b),
    .rec       (if_b.master),
    .busy      (busy_b),
    .done      (done_b),
    .vec_count (vec_b),
    .hit_count (hit_b)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Runs one sweep on instance A from a start pulse. Optionally stalls the
  // consumer for 5 cycles on stall_vec, re-pulses start on restart_vec, and
  // kills the sweep on kill_vec with abort (kind 1) or reset (kind 2).
  // Returns the number of accepted records and the cycle done was seen
  // (-1 if never), counting the start cycle as cycle 0.
  task automatic sweep_a(input int stall_vec, input int restart_vec,
                         input int kill_vec, input int kill_kind,
                         output int n_rec, output int done_cyc);
    int exp_vec;
    int cyc;
    int appear;
    int held;
    bit seen;
    exp_vec  = 0;
    appear   = 2;
    held     = 0;
    seen     = 1'b0;
    n_rec    = 0;
    done_cyc = -1;
    ready_a  = 1'b1;
    start_a  = 1'b1;
    @(negedge ck);
    cyc = 1;
    while (cyc < 400) begin
      start_a = 1'b0;
      if (done_a) begin
        done_cyc = cyc;
        return;
      end
      if (!busy_a) begin
        check("busy_in_sweep", 32'(busy_a), 32'd1);
        return;
      end
      if (if_a.rec_valid) begin
        if (!seen) begin
          seen = 1'b1;
          check("rec_vector", 32'(if_a.rec_vector), 32'(exp_vec));
          check("rec_out", 32'(if_a.rec_out), (mode_a == 1 && exp_vec == 31) ? 32'd1 : 32'd0);
          check("rec_time", 32'(cyc), 32'(appear));
          check("n_at_rec", 32'(n_a), 32'(exp_vec));
          if (exp_vec == restart_vec) start_a = 1'b1;
          if (exp_vec == kill_vec) begin
            ready_a = 1'b1;
            if (kill_kind == 1) abort_s = 1'b1;
            else reset_s = 1'b1;
            @(negedge ck);
            abort_s = 1'b0;
            reset_s = 1'b0;
            return;
          end
        end
        if (exp_vec == stall_vec && held < 5) begin
          ready_a = 1'b0;
          held++;
          check("hold_valid", 32'(if_a.rec_valid), 32'd1);
          check("hold_vector", 32'(if_a.rec_vector), 32'(stall_vec));
          check("hold_n", 32'(n_a), 32'(stall_vec));
        end else begin
          ready_a = 1'b1;
        end
        if (ready_a) begin
          n_rec++;
          exp_vec++;
          seen   = 1'b0;
          appear = cyc + 2;
        end
      end
      @(negedge ck);
      cyc++;
    end
  endtask

  initial begin
    int nr;
    int dc;
    int cyc;
    int exp_vec;
    int appear;
    bit done_seen;

    reset_s = 1'b1;
    abort_s = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    ready_a = 1'b1;
    mode_a  = 0;
    repeat (3) @(negedge ck);
    reset_s = 1'b0;
    @(negedge ck);

    // Reset state
    check("rst_n", 32'(n_a), 32'd0);
    check("rst_valid", 32'(if_a.rec_valid), 32'd0);
    check("rst_vector", 32'(if_a.rec_vector), 32'd0);
    check("rst_out", 32'(if_a.rec_out), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_vec", 32'(vec_a), 32'd0);
    check("rst_hit", 32'(hit_a), 32'd0);
    check("rst_busy_b", 32'(busy_b), 32'd0);

    // abort and start together in IDLE: abort wins
    abort_s = 1'b1;
    start_a = 1'b1;
    @(negedge ck);
    abort_s = 1'b0;
    start_a = 1'b0;
    check("abort_start_idle", 32'(busy_a), 32'd0);
    @(negedge ck);
    check("abort_start_idle2", 32'(busy_a), 32'd0);

    // 1: plain sweep, dut_out=0
    sweep_a(-1, -1, -1, 0, nr, dc);
    check("t1_records", 32'(nr), 32'd32);
    check("t1_done_cyc", 32'(dc), 32'd65);
    check("t1_vec", 32'(vec_a), 32'd32);
    check("t1_hit", 32'(hit_a), 32'd0);
    @(negedge ck);
    check("t1_done_pulse", 32'(done_a), 32'd0);
    check("t1_idle", 32'(busy_a), 32'd0);
    check("t1_n_hold", 32'(n_a), 32'd31);
    check("t1_vec_hold", 32'(vec_a), 32'd32);

    // 2: dut_out = AND of all N bits
    mode_a = 1;
    sweep_a(-1, -1, -1, 0, nr, dc);
    check("t2_done_cyc", 32'(dc), 32'd65);
    check("t2_vec", 32'(vec_a), 32'd32);
    check("t2_hit", 32'(hit_a), 32'd1);
    mode_a = 0;
    @(negedge ck);

    // 3: backpressure on vector 7
    sweep_a(7, -1, -1, 0, nr, dc);
    check("t3_records", 32'(nr), 32'd32);
    check("t3_done_cyc", 32'(dc), 32'd70);
    check("t3_vec", 32'(vec_a), 32'd32);
    @(negedge ck);

    // 4: start re-pulse at 4 ignored, abort at 10
    sweep_a(-1, 4, 10, 1, nr, dc);
    check("t4_busy", 32'(busy_a), 32'd0);
    check("t4_valid", 32'(if_a.rec_valid), 32'd0);
    check("t4_done", 32'(done_a), 32'd0);
    check("t4_vec", 32'(vec_a), 32'd10);
    check("t4_n_hold", 32'(n_a), 32'd10);
    done_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge ck);
      if (done_a || busy_a) done_seen = 1'b1;
    end
    check("t4_quiet_after_abort", 32'(done_seen), 32'd0);
    sweep_a(-1, -1, -1, 0, nr, dc);
    check("t4_restart_done_cyc", 32'(dc), 32'd65);
    check("t4_restart_vec", 32'(vec_a), 32'd32);
    @(negedge ck);

    // 5: reset mid-sweep at vector 20
    sweep_a(-1, -1, 20, 2, nr, dc);
    check("t5_n", 32'(n_a), 32'd0);
    check("t5_valid", 32'(if_a.rec_valid), 32'd0);
    check("t5_vector", 32'(if_a.rec_vector), 32'd0);
    check("t5_busy", 32'(busy_a), 32'd0);
    check("t5_vec", 32'(vec_a), 32'd0);
    check("t5_hit", 32'(hit_a), 32'd0);
    done_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge ck);
      if (busy_a) done_seen = 1'b1;
    end
    check("t5_no_autostart", 32'(done_seen), 32'd0);

    // 6: SETTLE_CYCLES=3 with a delayed benchmark on N[4]
    start_b = 1'b1;
    @(negedge ck);
    start_b = 1'b0;
    cyc     = 1;
    exp_vec = 0;
    appear  = 4;
    dc      = -1;
    while (cyc < 600) begin
      if (done_b) begin
        dc = cyc;
        break;
      end
      if (if_b.rec_valid) begin
        check("t6_vector", 32'(if_b.rec_vector), 32'(exp_vec));
        check("t6_out", 32'(if_b.rec_out), 32'(exp_vec % 2));
        check("t6_time", 32'(cyc), 32'(appear));
        exp_vec++;
        appear = cyc + 4;
      end
      @(negedge ck);
      cyc++;
    end
    check("t6_records", 32'(exp_vec), 32'd32);
    check("t6_done_cyc", 32'(dc), 32'd129);
    check("t6_vec", 32'(vec_b), 32'd32);
    check("t6_hit", 32'(hit_b), 32'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exhaustive_vector_sequencer.md
Name: exhaustive_vector_sequencer

Overview:
Sequencing controller for the trojan-detection benchmark flow. It drives every input combination of an N_WIDTH-bit benchmark circuit in ascending order and waits a programmable settle time per vector. It then samples the circuit output and emits a (vector, output) record over a valid/ready handshake to the logging/compare stage, with running hit statistics. It replaces open-coded per-vector stimulus with one reusable, backpressure-aware sequencer.

Parameters:
N_WIDTH, 5, number of benchmark input bits (1..16)
OUT_WIDTH, 1, number of benchmark output bits (1..8)
SETTLE_CYCLES, 1, clock cycles between applying a vector and sampling dut_out (>=1)

Ports:
CK  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a sweep; honoured only in IDLE
abort  input  1  terminate sweep; returns to IDLE next edge, no done pulse
N  output  N_WIDTH  vector driven to benchmark, declared [0:N_WIDTH-1], N[0] is MSB
dut_out  input  OUT_WIDTH  benchmark output
rec_valid  output  1  record available
rec_ready  input  1  consumer accepts record when rec_valid && rec_ready
rec_vector  output  N_WIDTH  vector of current record
rec_out  output  OUT_WIDTH  sampled dut_out for rec_vector
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after last record accepted
vec_count  output  N_WIDTH+1  records accepted in current/last sweep
hit_count  output  N_WIDTH+1  accepted records with rec_out != 0

Behaviour:
- Reset values: state IDLE, N=0, rec_valid=0, rec_vector=0, rec_out=0, busy=0, done=0, vec_count=0, hit_count=0, settle counter=0. Reset overrides all other inputs, including mid-sweep.
- States: IDLE, SETTLE, EMIT, FINISH.
- IDLE: on start, N<=0, cnt<=SETTLE_CYCLES, vec_count<=0, hit_count<=0, go to SETTLE. start in any other state is ignored.
- SETTLE: cnt decrements each cycle. In the cycle cnt==1: rec_out<=dut_out, rec_vector<=N, rec_valid<=1, go to EMIT.
- EMIT: rec_valid, rec_vector, rec_out and N are held stable while rec_ready=0. No timeout.
- On handshake: rec_valid<=0, vec_count+1, hit_count+1 if rec_out!=0.
  - If N is all ones, go to FINISH.
  - Otherwise N<=N+1, cnt<=SETTLE_CYCLES, go to SETTLE.
- FINISH: done=1 for exactly one cycle, then go to IDLE. N holds the last vector. Counters hold until the next start.
- Throughput with rec_ready=1: one record every SETTLE_CYCLES+1 cycles. Full sweep from start to done is 2^N_WIDTH*(SETTLE_CYCLES+1)+1 cycles.
- N wrap-around is never produced: the all-ones vector terminates the sweep.
- abort in SETTLE/EMIT/FINISH: next edge state=IDLE, rec_valid=0, done stays 0. N and counters hold. abort has priority over a same-cycle handshake (that record is not counted).
- abort and start in the same cycle while IDLE: abort wins, sweep does not start.
- Counters are N_WIDTH+1 bits, so vec_count reaches 2^N_WIDTH without overflow.

Test Plan:
1. Defaults, rec_ready=1, dut_out=0, start pulse -> 32 records with rec_vector 0..31 in order, one every 2 cycles; done pulses 65 cycles after start; vec_count=32, hit_count=0.
2. Defaults, dut_out=AND of all N bits -> only the record with rec_vector=5'b11111 has rec_out=1; hit_count=1; done follows that record by one cycle.
3. Backpressure: rec_ready=0 for 5 cycles while rec_vector=7 -> rec_valid, rec_vector=7 and N=7 all held for 5 cycles; next record is 8; no vector skipped or duplicated; final vec_count=32.
4. start re-pulsed at vector 4 is ignored (sweep continues). abort at vector 10 -> IDLE next edge, rec_valid=0, no done, vec_count=10. A later start restarts at vector 0.
5. reset asserted while rec_vector=20 -> next edge: N=0, rec_valid=0, busy=0, counters=0. Sweep restarts only on a new start.
6. SETTLE_CYCLES=3, dut_out=N[4] delayed 2 cycles -> records spaced 4 cycles apart; all records correct; hit_count=16.
